// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and small types used by the pipeline stages.
// Architectural widths are defined once here so every stage agrees on them.
package cpu_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int ZERO_REG   = 31;

  // Source of the register-file write data in the WB stage.
  typedef enum logic {
    WB_SEL_RESULT = 1'b0,
    WB_SEL_LOAD   = 1'b1
  } wb_sel_e;

endpackage : cpu_pkg

// File: rtl/wb_data_mux.sv
// 2:1 write-back data select: memory load word or ALU result.
// Pure combinational; widths are passed through unchanged.
module wb_data_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] loaded,
  input  logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] data
);

  wb_sel_e sel_e;

  assign sel_e = wb_sel_e'(sel);

  // NOTE: default assigned before the case so no path leaves data unassigned (no latch).
  always_comb begin
    data = result;
    case (sel_e)
      WB_SEL_LOAD:   data = loaded;
      WB_SEL_RESULT: data = result;
      default:       data = result;
    endcase
  end

endmodule : wb_data_mux

// File: rtl/write_back.sv
// WB stage: registers the MEM-stage results, selects the write data and
// qualifies the register-file write enable (writes to XZR are dropped).
module write_back #(
  parameter int DATA_W   = cpu_pkg::XLEN,
  parameter int REG_W    = cpu_pkg::REG_ADDR_W,
  parameter int ZERO_REG = cpu_pkg::ZERO_REG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  Instruction,
  input  logic [DATA_W-1:0] loadedData,
  input  logic [DATA_W-1:0] Results,
  input  logic              MemToReg,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] Data2Write,
  output logic [REG_W-1:0]  Reg2Write,
  output logic              oldRegWrite
);

  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_loaded;
  logic [DATA_W-1:0] wb_result;
  logic              wb_mem_to_reg;
  logic              wb_reg_write;

  // NOTE: state registers use non-blocking assignments so all captures see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rd         <= '0;
      wb_loaded     <= '0;
      wb_result     <= '0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
    end else begin
      wb_rd         <= Instruction;
      wb_loaded     <= loadedData;
      wb_result     <= Results;
      wb_mem_to_reg <= MemToReg;
      wb_reg_write  <= RegWrite;
    end
  end

  wb_data_mux #(
    .DATA_W (DATA_W)
  ) u_data_mux (
    .sel    (wb_mem_to_reg),
    .loaded (wb_loaded),
    .result (wb_result),
    .data   (Data2Write)
  );

  assign Reg2Write = wb_rd;

  // XZR is hard-wired to zero, so a write aimed at it never reaches the register file.
  assign oldRegWrite = wb_reg_write && (wb_rd != REG_W'(ZERO_REG));

endmodule : write_back

// File: tb/tb_write_back.sv
// Self-checking bench for the WB stage: directed vector table, reset
// sequences and a randomized run against a one-deep transaction model.
module tb_write_back;

  localparam int DW = 64;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] Instruction;
  logic [DW-1:0] loadedData;
  logic [DW-1:0] Results;
  logic          MemToReg;
  logic          RegWrite;
  logic [DW-1:0] Data2Write;
  logic [RW-1:0] Reg2Write;
  logic          oldRegWrite;

  int total = 0;
  int bad   = 0;

  write_back dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Instruction (Instruction),
    .loadedData  (loadedData),
    .Results     (Results),
    .MemToReg    (MemToReg),
    .RegWrite    (RegWrite),
    .Data2Write  (Data2Write),
    .Reg2Write   (Reg2Write),
    .oldRegWrite (oldRegWrite)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [RW-1:0] rd;
    logic [DW-1:0] ld;
    logic [DW-1:0] res;
    logic          mtr;
    logic          rw;
    logic [DW-1:0] exp_data;
    logic [RW-1:0] exp_rd;
    logic          exp_en;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [DW-1:0] actual,
                       input logic [DW-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic check_outs(input string name, input logic [DW-1:0] data,
                            input logic [RW-1:0] rd, input logic en);
    check({name, ".data"}, Data2Write, data);
    check({name, ".rd"}, DW'(Reg2Write), DW'(rd));
    check({name, ".en"}, DW'(oldRegWrite), DW'(en));
  endtask

  task automatic drive(input logic [RW-1:0] rd, input logic [DW-1:0] ld,
                       input logic [DW-1:0] res, input logic mtr, input logic rw);
    @(negedge clk);
    Instruction = rd;
    loadedData  = ld;
    Results     = res;
    MemToReg    = mtr;
    RegWrite    = rw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{"alu",      5'd3,  64'hDEAD_BEEF_0000_0000, 64'h1234, 1'b0, 1'b1,
                64'h1234, 5'd3, 1'b1};
    vecs[1] = '{"load",     5'd3,  64'hDEAD_BEEF_0000_0000, 64'h1234, 1'b1, 1'b1,
                64'hDEAD_BEEF_0000_0000, 5'd3, 1'b1};
    vecs[2] = '{"xzr",      5'd31, 64'h0, 64'd7, 1'b0, 1'b1, 64'd7, 5'd31, 1'b0};
    vecs[3] = '{"b2b_a",    5'd1,  64'h0, 64'd10, 1'b0, 1'b1, 64'd10, 5'd1, 1'b1};
    vecs[4] = '{"b2b_b",    5'd2,  64'h0, 64'd20, 1'b0, 1'b0, 64'd20, 5'd2, 1'b0};
    vecs[5] = '{"mtr_norw", 5'd9,  64'hFFFF_FFFF_FFFF_FFFF, 64'h55, 1'b1, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 1'b0};
    vecs[6] = '{"r30",      5'd30, 64'h8000_0000_0000_0001, 64'h0, 1'b1, 1'b1,
                64'h8000_0000_0000_0001, 5'd30, 1'b1};
    vecs[7] = '{"r0",       5'd0,  64'h1, 64'hFFFF_0000_FFFF_0000, 1'b0, 1'b1,
                64'hFFFF_0000_FFFF_0000, 5'd0, 1'b1};

    // Reset held: outputs cleared with no dependence on a clock edge.
    rst_n       = 1'b0;
    Instruction = 5'd5;
    loadedData  = 64'hAAAA;
    Results     = 64'hBBBB;
    MemToReg    = 1'b0;
    RegWrite    = 1'b1;
    #1;
    check_outs("reset", 64'h0, 5'd0, 1'b0);
    step();
    check_outs("reset_held", 64'h0, 5'd0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].rd, vecs[i].ld, vecs[i].res, vecs[i].mtr, vecs[i].rw);
      step();
      check_outs(vecs[i].name, vecs[i].exp_data, vecs[i].exp_rd, vecs[i].exp_en);
    end

    // Undefined load data must not leak through when the ALU result is selected.
    drive(5'd4, 'x, 64'h0BAD_F00D, 1'b0, 1'b1);
    step();
    check_outs("x_load", 64'h0BAD_F00D, 5'd4, 1'b1);

    // Outputs hold between edges while inputs change.
    drive(5'd12, 64'h11, 64'h22, 1'b0, 1'b0);
    #1;
    check_outs("hold", 64'h0BAD_F00D, 5'd4, 1'b1);

    // Reset mid-stream drops the in-flight write immediately.
    drive(5'd7, 64'h0, 64'h77, 1'b0, 1'b1);
    step();
    check_outs("pre_midrst", 64'h77, 5'd7, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs("midrst", 64'h0, 5'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(5'd8, 64'h0, 64'h88, 1'b0, 1'b1);
    step();
    check_outs("post_midrst", 64'h88, 5'd8, 1'b1);

    // Randomized run: the model is "outputs equal the rules applied to the
    // transaction presented one edge earlier".
    for (int n = 0; n < 300; n++) begin
      logic [RW-1:0] rd;
      logic [DW-1:0] ld, res;
      logic          mtr, rw;
      rd  = ($urandom_range(0, 3) == 0) ? 5'd31 : RW'($urandom);
      ld  = {$urandom, $urandom};
      res = {$urandom, $urandom};
      mtr = 1'($urandom);
      rw  = 1'($urandom);
      drive(rd, ld, res, mtr, rw);
      step();
      check_outs("rand", mtr ? ld : res, rd, rw && (int'(rd) != 31));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule : tb_write_back
